// File: rtl/sign_extend.sv
// Immediate generator: extracts and sign-extends the immediate field of an
// instruction word for the selected format, with a registered debug copy.
module sign_extend (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] In,
  input  logic [1:0]  ImmSrc,
  output logic [31:0] Imm_Ext,
  output logic [31:0] Imm_Ext_q
);

  logic sgn;

  assign sgn = In[31];

  // Format comes only from ImmSrc; the opcode bits are never inspected.
  always_comb begin
    Imm_Ext = '0;
    unique case (ImmSrc)
      2'b00: Imm_Ext = {{20{sgn}}, In[31:20]};
      2'b01: Imm_Ext = {{20{sgn}}, In[31:25],
                        In[11:7]};
      2'b10: Imm_Ext = {{19{sgn}}, sgn, In[7],
                        In[30:25], In[11:8],
                        1'b0};
      2'b11: Imm_Ext = {{11{sgn}}, sgn,
                        In[19:12], In[20],
                        In[30:21], 1'b0};
      default: Imm_Ext = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Imm_Ext_q <= '0;
    else     Imm_Ext_q <= Imm_Ext;
  end

endmodule

// File: tb/tb_sign_extend.sv
// Scoreboarded random and directed bench for sign_extend.
// Reference computes signed field values arithmetically.
module tb_sign_extend;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] In;
  logic [1:0]  ImmSrc;
  logic [31:0] Imm_Ext;
  logic [31:0] Imm_Ext_q;

  typedef struct {
    logic [31:0] comb;
    logic [31:0] q;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] prev = '0;

  sign_extend dut (
    .clk      (clk),
    .rst      (rst),
    .In       (In),
    .ImmSrc   (ImmSrc),
    .Imm_Ext  (Imm_Ext),
    .Imm_Ext_q(Imm_Ext_q)
  );

  always #5 clk = ~clk;

  // Immediate value as a signed number, scaled for branch/jump offsets.
  function automatic logic [31:0] ref_imm(
    input logic [31:0] w,
    input logic [1:0]  s
  );
    logic [11:0] f12;
    logic [19:0] f20;
    int          v;
    v = 0;
    case (s)
      2'd0: begin
        f12 = w[31:20];
        v   = int'($signed(f12));
      end
      2'd1: begin
        f12 = {w[31:25], w[11:7]};
        v   = int'($signed(f12));
      end
      2'd2: begin
        f12 = {w[31], w[7], w[30:25], w[11:8]};
        v   = int'($signed(f12)) * 2;
      end
      default: begin
        f20 = {w[31], w[19:12], w[20], w[30:21]};
        v   = int'($signed(f20)) * 2;
      end
    endcase
    return v;
  endfunction

  task automatic chk(
    input string       n,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               n, act, exp);
    end
  endtask

  task automatic drive(
    input logic [31:0] w,
    input logic [1:0]  s,
    input string       n
  );
    logic [31:0] rq;
    @(posedge clk);
    rq = rst ? 32'h0 : prev;
    #1;
    In     = w;
    ImmSrc = s;
    prev   = ref_imm(w, s);
    sb.push_back('{prev, rq, n});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, "_comb"}, Imm_Ext, e.comb);
      chk({e.name, "_q"}, Imm_Ext_q, e.q);
    end
  end

  initial begin
    logic [31:0] w;
    logic [1:0]  s;
    int          k;
    In     = '0;
    ImmSrc = '0;
    rst    = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_q", Imm_Ext_q, 32'h0);
    chk("reset_comb", Imm_Ext, 32'h0);

    drive(32'h0000155A, 2'd0, "rst_hold");
    rst = 1'b0;

    drive(32'h0000155A, 2'd0, "i_pos");
    chk("i_pos_plan", ref_imm(In, ImmSrc),
        32'h00000000);
    drive(32'hFFFFFFE0, 2'd0, "i_neg");
    drive(32'h0000355A, 2'd1, "s_pos");
    chk("s_pos_plan", ref_imm(In, ImmSrc),
        32'h0000000A);
    drive(32'hFFFFCFE0, 2'd1, "s_neg");
    drive(32'h0000055A, 2'd2, "b_pos");
    drive(32'hFFFFEFE0, 2'd2, "b_neg");
    drive(32'h00100000, 2'd3, "j_b11");
    drive(32'h80000000, 2'd3, "j_sgn");

    for (int i = 0; i < 4; i++)
      drive(32'hFFFFEFE0, 2'(i), "sweep");

    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      s = 2'($urandom_range(0, 3));
      drive(w, s, "rand");
    end

    @(posedge clk);
    #1;
    In     = 32'h0000155A;
    ImmSrc = 2'd1;
    prev   = ref_imm(In, ImmSrc);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q", Imm_Ext_q, 32'h0);
    chk("mid_rst_comb", Imm_Ext, 32'h0000000A);
    sb.push_back('{prev, 32'h0, "mid_rst"});
    drive(32'h0000155A, 2'd1, "in_rst");
    drive(32'h0000155A, 2'd1, "rel_rst");
    rst = 1'b0;
    drive(32'h0000155A, 2'd1, "post_rst");
    drive(32'h0000155A, 2'd1, "post_rst2");

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d left, want 0",
               sb.size());
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
